// File: rtl/myproject_mul_share_pkg.sv
// Shared types for the time-multiplexed signed multiplier: operand/product widths and
// the output-register state encoding.
package myproject_mul_share_pkg;

    localparam int unsigned A_W = 13;
    localparam int unsigned B_W = 9;
    localparam int unsigned P_W = 22;

    typedef logic signed [A_W-1:0] opa_t;
    typedef logic signed [B_W-1:0] opb_t;
    typedef logic signed [P_W-1:0] prod_t;

    typedef enum logic {
        OREG_EMPTY = 1'b0,
        OREG_FULL  = 1'b1
    } oreg_state_t;

    // Round-robin successor of a granted lane index.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned nreq);
        return (g == nreq - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/myproject_mul_share_core.sv
// Single shared signed multiplier; purely combinational, full-precision 22b product.
module myproject_mul_share_core
    import myproject_mul_share_pkg::*;
(
    input  opa_t  i_a,
    input  opb_t  i_b,
    output prod_t o_p
);

    // Sign-extend both operands to product width; the true product always fits.
    assign o_p = prod_t'(i_a) * prod_t'(i_b);

endmodule

// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter sharing one signed multiplier among NREQ requesters, with a
// registered valid/ready result channel tagged by requester index.
module myproject_mul_share_arb
    import myproject_mul_share_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*A_W-1:0]     req_a,
    input  logic [NREQ*B_W-1:0]     req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [IDW-1:0]          res_id,
    output logic signed [P_W-1:0]   res_p,
    output logic [CNTW-1:0]         op_count
);

    oreg_state_t     r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_res_id;
    prod_t           r_res_p;
    logic [CNTW-1:0] r_op_count;

    opa_t            w_lane_a [NREQ];
    opb_t            w_lane_b [NREQ];
    opa_t            w_op_a;
    opb_t            w_op_b;
    prod_t           w_prod;

    int unsigned     w_scan_idx;
    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_can_issue;
    logic            w_issue;
    logic            w_res_xfer;

    // Unpack the flat operand buses into per-lane typed operands.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_lane_a[gi] = opa_t'(req_a[gi*A_W +: A_W]);
        assign w_lane_b[gi] = opb_t'(req_b[gi*B_W +: B_W]);
    end

    // Priority scan starting at rr_ptr, wrapping modulo NREQ; first valid lane wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_scan_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_scan_idx = 32'(r_rr_ptr) + k;
            if (w_scan_idx >= NREQ) begin
                w_scan_idx = w_scan_idx - NREQ;
            end
            if (!w_found && req_valid[IDW'(w_scan_idx)]) begin
                w_found = 1'b1;
                w_grant = IDW'(w_scan_idx);
            end
        end
    end

    assign w_can_issue = (r_state == OREG_EMPTY) || res_ready;
    assign w_issue     = w_found && w_can_issue && !ap_rst;
    assign w_res_xfer  = (r_state == OREG_FULL) && res_ready;
    assign w_next_ptr  = IDW'(rr_next(32'(w_grant), NREQ));

    // Ready is driven only from the scan result, never re-gated by the lane's own valid.
    always_comb begin
        req_ready = '0;
        if (w_issue) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_op_a = w_lane_a[w_grant];
    assign w_op_b = w_lane_b[w_grant];

    myproject_mul_share_core u_core (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_p (w_prod)
    );

    // Output register, round-robin pointer and accepted-result counter.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state    <= OREG_EMPTY;
            r_rr_ptr   <= '0;
            r_res_id   <= '0;
            r_res_p    <= '0;
            r_op_count <= '0;
        end else begin
            if (w_res_xfer) begin
                r_op_count <= r_op_count + CNTW'(1);
            end
            if (w_issue) begin
                r_state  <= OREG_FULL;
                r_res_p  <= w_prod;
                r_res_id <= w_grant;
                r_rr_ptr <= w_next_ptr;
            end else if (w_res_xfer) begin
                r_state  <= OREG_EMPTY;
            end
        end
    end

    assign res_valid = (r_state == OREG_FULL);
    assign res_id    = r_res_id;
    assign res_p     = r_res_p;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Randomized self-checking bench for the shared-multiplier arbiter against a
// cycle-level behavioural model of the result register, fairness pointer and counter.
module tb_myproject_mul_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*13-1:0]   req_a;
    logic [NREQ*9-1:0]    req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [IDW-1:0]       res_id;
    logic [21:0]          res_p;
    logic [CNTW-1:0]      op_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_valid, m_id, m_p, m_ptr, m_cnt;
    int la [NREQ];
    int lb [NREQ];

    always #5 ap_clk = ~ap_clk;

    myproject_mul_share_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .op_count  (op_count)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_p = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic rr);
        req_valid = v;
        res_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[13*i +: 13] = 13'(la[i]);
            req_b[9*i +: 9]   = 9'(lb[i]);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            la[i] = int'($urandom_range(0, 8191)) - 4096;
            lb[i] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    // One clock: check ready against the model, advance the model, check outputs after the edge.
    task automatic cycle();
        int g;
        int lane;
        bit can;
        logic [NREQ-1:0] exp_rdy;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            lane = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[lane]) g = lane;
        end
        can = (m_valid == 0) || res_ready;
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", longint'(req_ready), longint'(exp_rdy));
        if (m_valid != 0 && res_ready) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_valid = 0;
        end
        if (can && g >= 0) begin
            m_valid = 1;
            m_id    = g;
            m_p     = la[g] * lb[g];
            m_ptr   = (g + 1) % NREQ;
        end
        @(posedge ap_clk);
        #1;
        check("res_valid", longint'(res_valid), longint'(m_valid));
        check("op_count", longint'(op_count), longint'(m_cnt));
        if (m_valid != 0) begin
            check("res_id", longint'(res_id), longint'(m_id));
            check("res_p", longint'($signed(res_p)), longint'(m_p));
        end
        @(negedge ap_clk);
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp_seq [5];
        int held;
        exp_seq = '{0, 1, 2, 3, 0};
        ap_rst = 1'b1;
        rand_ops();
        drive('0, 1'b0);
        model_reset();
        do_reset();
        #1;
        check("rst_valid", longint'(res_valid), 0);
        check("rst_count", longint'(op_count), 0);
        check("rst_ready", longint'(req_ready), 0);
        @(negedge ap_clk);

        // Build state, then hit async reset mid-cycle while holding a result.
        for (int i = 0; i < 3; i++) begin
            rand_ops(); drive('1, 1'b1); cycle();
        end
        rand_ops(); drive('1, 1'b0); cycle();
        drive('1, 1'b1);
        #2 ap_rst = 1'b1;
        #1;
        check("async_valid", longint'(res_valid), 0);
        check("async_count", longint'(op_count), 0);
        check("async_p", longint'($signed(res_p)), 0);
        check("async_id", longint'(res_id), 0);
        check("async_ready", longint'(req_ready), 0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_reset();

        // Round robin from a freshly reset pointer.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                la[j] = 100 * (j + 1) + i; lb[j] = -(j + 3);
            end
            drive('1, 1'b1); cycle();
            check("rr_id", longint'(res_id), exp_seq[i]);
        end

        // Single lane extreme negative-by-negative.
        do_reset();
        la[2] = -4096; lb[2] = -256;
        drive(4'b0100, 1'b1); cycle();
        check("single_p", longint'($signed(res_p)), 1048576);
        check("single_id", longint'(res_id), 2);
        drive('0, 1'b1); cycle();
        check("single_cnt", longint'(op_count), 1);

        // Operand extremes on lane 0.
        la[0] = 4095;  lb[0] = 255;  drive(4'b0001, 1'b1); cycle();
        check("ext_pp", longint'($signed(res_p)), 1044225);
        la[0] = -4096; lb[0] = 255;  drive(4'b0001, 1'b1); cycle();
        check("ext_np", longint'($signed(res_p)), -1044480);
        la[0] = 4095;  lb[0] = -256; drive(4'b0001, 1'b1); cycle();
        check("ext_pn", longint'($signed(res_p)), -1048320);

        // Backpressure: hold for 5 cycles, then next grant follows the held id.
        rand_ops(); drive('1, 1'b1); cycle();
        held = m_id;
        for (int i = 0; i < 5; i++) begin
            rand_ops(); drive('1, 1'b0); cycle();
            check("bp_id", longint'(res_id), held);
        end
        rand_ops(); drive('1, 1'b1); cycle();
        check("bp_next", longint'(res_id), (held + 1) % NREQ);

        // Random traffic with random backpressure and drop-outs.
        for (int i = 0; i < 1500; i++) begin
            rand_ops();
            drive(NREQ'($urandom), ($urandom_range(0, 9) < 7));
            cycle();
        end

        // Counter wrap: 65537 accepted results from reset.
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            rand_ops(); drive('1, 1'b1); cycle();
        end
        drive('0, 1'b1); cycle();
        check("wrap_cnt", longint'(op_count), 1);
        check("wrap_valid", longint'(res_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
